// File: rtl/muon_pkg.sv
// Shared record layout and defaults for the muon readout chain.
package muon_pkg;
  localparam int ID_W     = 16;
  localparam int CNT_W    = 8;
  localparam int TIME_W   = 32;
  localparam int REC_W    = ID_W + CNT_W + TIME_W;
  localparam int TIME_LSB = 0;
  localparam int CNT_LSB  = TIME_LSB + TIME_W;
  localparam int ID_LSB   = CNT_LSB + CNT_W;

  localparam int unsigned GATE_DEFAULT = 50_000_000;

  function automatic logic [REC_W-1:0] pack_rec(input logic [ID_W-1:0] id,
                                                input logic [CNT_W-1:0] dcnt,
                                                input logic [TIME_W-1:0] dtime);
    return {id, dcnt, dtime};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; head entry is always visible on pop_data.
module sync_fifo #(
  parameter int DATA_W = 56,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty    = (level == '0);
  assign full     = (level == (ADDR_W + 1)'(DEPTH));
  assign pop_ok   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
    end
  end
endmodule

// File: rtl/muon_rate_logger.sv
// Per-gate-window delta logger for the muon pulse counter, buffered onto a valid/ready record stream.
module muon_rate_logger
  import muon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_DEFAULT,
  parameter int          FIFO_AW     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [7:0]         count,
  input  logic [31:0]        count_time,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [55:0]        rec_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         drop_cnt,
  output logic               overflow
);
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  logic [31:0]       gate_cnt;
  logic [ID_W-1:0]   window_id;
  logic [CNT_W-1:0]  prev_count;
  logic [TIME_W-1:0] prev_time;
  logic              window_end;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;
  logic [REC_W-1:0]  record;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign window_end = enable & (gate_cnt == GATE_LAST);
  // Modular subtraction absorbs counter-stage wrap between windows.
  assign record     = pack_rec(window_id, count - prev_count, count_time - prev_time);
  assign drop       = window_end & fifo_full & ~rec_ready;
  assign rec_valid  = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt   <= '0;
      window_id  <= '0;
      prev_count <= '0;
      prev_time  <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (!enable) begin
        gate_cnt   <= '0;
        prev_count <= count;
        prev_time  <= count_time;
      end else if (window_end) begin
        gate_cnt   <= '0;
        prev_count <= count;
        prev_time  <= count_time;
        window_id  <= window_id + 1'b1;
      end else begin
        gate_cnt <= gate_cnt + 32'd1;
      end
      if (drop) begin
        drop_cnt <= sat_inc8(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .DATA_W(REC_W),
    .ADDR_W(FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (window_end),
    .push_data (record),
    .pop       (rec_ready),
    .pop_data  (rec_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule
